board_stream_tx: RTL and testbench

- Reader/transmitter side of the game-step result path.
- When the step engine signals a completed step, this block snapshots the stored 80-bit board and its stuck flag.
- It serialises them as a framed byte stream over a valid/ready handshake toward a host/display link.
- Per snapshot it also reports a running step count, the max tile exponent and the empty-cell count.

---
 rtl/board_pkg.sv | 21 ++
 rtl/board_stats.sv | 19 +
 rtl/board_stream_tx.sv | 105 ++++++++++
 tb/tb_board_stream_tx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// board_pkg: shared board geometry, frame constants and transmitter state encoding.
package board_pkg;

    localparam int CELLS   = 16;
    localparam int CELL_W  = 5;
    localparam int BOARD_W = CELLS * CELL_W;

    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int         FRAME_LEN = 21;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_INFO,
        ST_STEP_HI,
        ST_STEP_LO,
        ST_CELLS,
        ST_CSUM
    } tx_state_e;

endpackage

// File: rtl/board_stats.sv
// board_stats: combinational max tile exponent and empty-cell count of a board.
module board_stats
    import board_pkg::*;
(
    input  logic [BOARD_W-1:0] board_i,
    output logic [CELL_W-1:0]  max_tile_o,
    output logic [4:0]         empty_cnt_o
);

    always_comb begin
        max_tile_o  = '0;
        empty_cnt_o = '0;
        for (int i = 0; i < CELLS; i++) begin
            max_tile_o  = (board_i[i*CELL_W +: CELL_W] > max_tile_o) ? board_i[i*CELL_W +: CELL_W] : max_tile_o;
            empty_cnt_o = empty_cnt_o + 5'(board_i[i*CELL_W +: CELL_W] == '0);
        end
    end

endmodule

// File: rtl/board_stream_tx.sv
// board_stream_tx: snapshots a completed board and streams it as a 21-byte framed,
// XOR-checksummed byte sequence over a valid/ready handshake.
module board_stream_tx
    import board_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BOARD_W-1:0] board_in,
    input  logic               stuck_in,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               out_last,
    output logic               frame_done,
    output logic [15:0]        step_count,
    output logic [CELL_W-1:0]  max_tile,
    output logic [4:0]         empty_cnt,
    output logic               overrun
);

    tx_state_e          state_q, state_d;
    logic [3:0]         idx_q;
    logic [BOARD_W-1:0] board_q;
    logic               stuck_q;
    logic [7:0]         csum_q;
    logic [15:0]        step_q;
    logic [CELL_W-1:0]  max_q, max_d;
    logic [4:0]         empty_q, empty_d;
    logic               overrun_q;
    logic               done_q;

    board_stats u_stats (
        .board_i     (board_in),
        .max_tile_o  (max_d),
        .empty_cnt_o (empty_d)
    );

    // Byte on the wire depends only on registered state, so it holds while stalled.
    always_comb begin
        state_d  = state_q;
        out_data = 8'h00;
        case (state_q)
            ST_HDR:     begin out_data = FRAME_HDR;                          state_d = ST_INFO;    end
            ST_INFO:    begin out_data = {stuck_q, 2'b00, empty_q};          state_d = ST_STEP_HI; end
            ST_STEP_HI: begin out_data = step_q[15:8];                       state_d = ST_STEP_LO; end
            ST_STEP_LO: begin out_data = step_q[7:0];                        state_d = ST_CELLS;   end
            ST_CELLS:   begin
                out_data = 8'(board_q[32'(idx_q)*CELL_W +: CELL_W]);
                state_d  = (idx_q == 4'hF) ? ST_CSUM : ST_CELLS;
            end
            ST_CSUM:    begin out_data = csum_q;                             state_d = ST_IDLE;    end
            default:    begin out_data = 8'h00;                              state_d = ST_IDLE;    end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            board_q   <= '0;
            stuck_q   <= 1'b0;
            csum_q    <= '0;
            step_q    <= '0;
            max_q     <= '0;
            empty_q   <= '0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start && busy)
                overrun_q <= 1'b1;
            if (state_q == ST_IDLE) begin
                if (start) begin
                    board_q <= board_in;
                    stuck_q <= stuck_in;
                    step_q  <= step_q + 16'd1;
                    max_q   <= max_d;
                    empty_q <= empty_d;
                    csum_q  <= '0;
                    idx_q   <= '0;
                    state_q <= ST_HDR;
                end
            end else if (out_ready) begin
                csum_q  <= csum_q ^ out_data;
                state_q <= state_d;
                if (state_q == ST_CELLS)
                    idx_q <= idx_q + 4'd1;
                if (state_q == ST_CSUM)
                    done_q <= 1'b1;
            end
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = busy;
    assign out_last   = (state_q == ST_CSUM);
    assign frame_done = done_q;
    assign step_count = step_q;
    assign max_tile   = max_q;
    assign empty_cnt  = empty_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_board_stream_tx.sv
// tb_board_stream_tx: scoreboard bench; stimulus queues expected frame bytes, a negedge monitor checks transfers.
module tb_board_stream_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [79:0] board_in = '0;
    logic        stuck_in = 1'b0;
    logic        busy, out_valid, out_last, frame_done, overrun;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic [15:0] step_count;
    logic [4:0]  max_tile, empty_cnt;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [8:0]  q[$];
    logic [15:0] exp_step = 16'h0000;

    board_stream_tx dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .board_in   (board_in),
        .stuck_in   (stuck_in),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done),
        .step_count (step_count),
        .max_tile   (max_tile),
        .empty_cnt  (empty_cnt),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference frame: header, info, step, 16 zero-extended cells, XOR of all before.
    task automatic push_frame(input logic [79:0] b, input logic s, input logic [15:0] st);
        logic [7:0] bytes[20];
        logic [7:0] cs;
        logic [4:0] e;
        e = 0;
        for (int i = 0; i < 16; i++) if (b[i*5 +: 5] == 5'd0) e++;
        bytes[0] = 8'hA5;
        bytes[1] = {s, 2'b00, e};
        bytes[2] = st[15:8];
        bytes[3] = st[7:0];
        for (int i = 0; i < 16; i++) bytes[4+i] = {3'b000, b[i*5 +: 5]};
        cs = 8'h00;
        for (int i = 0; i < 20; i++) begin
            cs ^= bytes[i];
            q.push_back({1'b0, bytes[i]});
        end
        q.push_back({1'b1, cs});
    endtask

    task automatic start_frame(input logic [79:0] b, input logic s, input bit use_model);
        exp_step = exp_step + 16'd1;
        if (use_model) push_frame(b, s, exp_step);
        board_in = b;
        stuck_in = s;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        for (int i = 0; i < 400; i++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
            if (frame_done) begin
                out_ready = 1'b1;
                return;
            end
        end
        out_ready = 1'b1;
        n_chk++;
        $display("FAIL frame_done_timeout: got no frame_done expected one within 400 cycles");
    endtask

    logic       prev_stall = 1'b0;
    logic       prev_last = 1'b0;
    logic [9:0] prev_word = '0;
    int         nx = 0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
            prev_last  = 1'b0;
            nx         = 0;
        end else begin
            if (prev_stall) chk("stall_hold", {22'd0, out_valid, out_last, out_data}, {22'd0, prev_word});
            if (frame_done || prev_last) begin
                chk("frame_done", {31'd0, frame_done}, {31'd0, prev_last});
                if (frame_done) begin
                    chk("xfer_count", nx, 21);
                    nx = 0;
                end
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_byte: got %h expected none", out_data);
                end else begin
                    chk("byte", {23'd0, out_last, out_data}, {23'd0, q.pop_front()});
                end
                nx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_last  = out_valid && out_ready && out_last;
            prev_word  = {out_valid, out_last, out_data};
        end
    end

    logic [79:0] b2, b3, b4, b4x, b6;

    initial begin
        for (int i = 0; i < 16; i++) begin
            b2[i*5 +: 5]  = 5'(i + 1);
            b3[i*5 +: 5]  = (i % 3 == 0) ? 5'd0 : 5'(i * 2);
            b4[i*5 +: 5]  = 5'(31 - i);
            b4x[i*5 +: 5] = 5'd7;
            b6[i*5 +: 5]  = 5'(i ^ 5);
        end

        #12;
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_step", {16'd0, step_count}, 0);
        chk("rst_stats", {22'd0, max_tile, empty_cnt}, 0);
        chk("rst_overrun_done", {30'd0, overrun, frame_done}, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // All-zero board: hand-written frame.
        q.push_back(9'h0A5); q.push_back(9'h010); q.push_back(9'h000); q.push_back(9'h001);
        for (int i = 0; i < 16; i++) q.push_back(9'h000);
        q.push_back(9'h1B4);
        start_frame('0, 1'b0, 1'b0);
        chk("zero_stats", {22'd0, max_tile, empty_cnt}, {22'd0, 5'd0, 5'd16});
        chk("zero_step", {16'd0, step_count}, 32'h0001);
        wait_done(1'b0);

        // Exponents 1..16, stuck.
        start_frame(b2, 1'b1, 1'b1);
        chk("b2_stats", {22'd0, max_tile, empty_cnt}, {22'd0, 5'd16, 5'd0});
        chk("b2_info", {24'd0, q[1][7:0]}, 32'h80);
        wait_done(1'b0);

        // Backpressure: STEP_LO stalled 5 cycles, then random ready.
        start_frame(b3, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        chk("bp_byte3", {24'd0, out_data}, 32'h03);
        repeat (5) @(posedge clk);
        #1;
        wait_done(1'b1);

        // Start while busy, then start during the frame_done cycle.
        start_frame(b4, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        board_in = b4x;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("ovr_flag", {31'd0, overrun}, 1);
        chk("ovr_step", {16'd0, step_count}, 32'h0004);
        wait_done(1'b0);
        start_frame(b4x, 1'b1, 1'b1);
        chk("b2b_hdr", {23'd0, out_valid, out_data}, 32'h1A5);
        wait_done(1'b0);

        // Reset while cell 7 is presented.
        start_frame(b6, 1'b0, 1'b1);
        repeat (11) @(posedge clk);
        #1;
        chk("pre_rst_cell7", {24'd0, out_data}, {27'd0, b6[35 +: 5]});
        rst = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_outs", {28'd0, out_valid, busy, overrun, frame_done}, 0);
        chk("mid_rst_step", {16'd0, step_count}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_step = 16'h0000;
        start_frame(b6, 1'b0, 1'b1);
        chk("post_rst_step", {16'd0, step_count}, 32'h0001);
        wait_done(1'b0);

        // Step counter wrap.
        force dut.step_q = 16'hFFFF;
        #1 release dut.step_q;
        chk("preload_step", {16'd0, step_count}, 32'hFFFF);
        exp_step = 16'hFFFF;
        start_frame(b2, 1'b0, 1'b1);
        chk("wrap_step", {16'd0, step_count}, 32'h0000);
        wait_done(1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
